sd_cmd_responder: RTL and testbench

Card-side endpoint of the SD CMD line; the responder to the host-side command sequencer in sdhc.
- Oversamples the host-driven sd_clk on the system clock.
- Deserialises 48-bit host commands, checks framing and CRC7, and hands index/argument to device logic.
- Serialises the device's 48-bit R1-format response back onto CMD, honouring the NCR gap.
- Used for SD-device emulation and as a synthesizable bench partner for sdhc.

---
 rtl/sd_pkg.sv | 34 +++
 rtl/crc7.sv | 21 ++
 rtl/sd_cmd_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: frame constants, FSM states, R1 field widths
// and the serial CRC7 step used by host and card sides.
package sd_pkg;

    localparam int FRAME_LEN  = 48;
    localparam int CRC_W      = 7;
    localparam int IDX_W      = 6;
    localparam int ARG_W      = 32;
    localparam int BIT_CNT_W  = 6;
    localparam int NCR_CNT_W  = 7;

    localparam logic START_BIT   = 1'b0;
    localparam logic HOST_TX_BIT = 1'b1;  // transmission bit in host->card frames
    localparam logic CARD_TX_BIT = 1'b0;  // transmission bit in card->host frames
    localparam logic END_BIT     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT_RSP,
        ST_TX,
        ST_TX_END
    } sd_state_e;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [CRC_W-1:0] crc7_next(input logic [CRC_W-1:0] crc,
                                                    input logic din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 accumulator; cleared by rst, advanced one bit per en strobe.
module crc7
    import sd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data,
    output logic [CRC_W-1:0] crc
);

    // Accumulate one bit per enable; rst wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_next(crc, data);
        end
    end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD endpoint: oversamples sd_clk, receives 48-bit host commands
// on sd_clk rise, and sends 48-bit R1 responses on sd_clk fall after the NCR gap.
//
// Response handshake: the device holds rsp_valid (with rsp_skip/index/arg stable)
// until it sees rsp_ready; a transfer happens on the clk where both are high.
// rsp_ready may depend combinationally on rsp_valid; rsp_valid must not depend on
// rsp_ready.
module sd_cmd_responder
    import sd_pkg::*;
#(
    parameter int NCR_MIN = 2,
    parameter int NCR_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sd_clk,
    input  logic             sd_cmd_in,
    output logic             sd_cmd_out,
    output logic             sd_cmd_oe,
    output logic             cmd_valid,
    output logic [IDX_W-1:0] cmd_index,
    output logic [ARG_W-1:0] cmd_arg,
    output logic             cmd_crc_ok,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic             rsp_skip,
    input  logic [IDX_W-1:0] rsp_index,
    input  logic [ARG_W-1:0] rsp_arg,
    output logic             rsp_dropped,
    output sd_state_e        fsm_state
);

    localparam logic [NCR_CNT_W-1:0] NCR_MIN_C = NCR_CNT_W'(NCR_MIN);
    localparam logic [NCR_CNT_W-1:0] NCR_MAX_C = NCR_CNT_W'(NCR_MAX);

    logic [1:0] clk_sync;
    logic       clk_d;
    logic [1:0] cmd_sync;
    logic       rise, fall, cmd_bit;

    sd_state_e              state, state_n;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [NCR_CNT_W-1:0]   ncr_cnt, ncr_n;
    logic [45:0]            rx_sr, rx_sr_n;   // last 46 received bits
    logic [46:0]            frame;            // bits 46..0 once bit 0 arrives
    logic [39:0]            tx_sr, tx_sr_n;
    logic [IDX_W-1:0]       idx_n;
    logic [ARG_W-1:0]       arg_n;
    logic                   ok_n, drop_n, out_n, oe_n;
    logic                   crc_rst, crc_en, crc_din;
    logic [CRC_W-1:0]       crc;
    logic [2:0]             crc_sel;

    // Synchronise sd_clk and CMD with matching delay, then detect sd_clk edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b00;
            clk_d    <= 1'b0;
            cmd_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], sd_clk};
            clk_d    <= clk_sync[1];
            cmd_sync <= {cmd_sync[0], sd_cmd_in};
        end
    end

    assign rise    = clk_sync[1] & ~clk_d;
    assign fall    = ~clk_sync[1] & clk_d;
    assign cmd_bit = cmd_sync[1];

    assign frame     = {rx_sr, cmd_bit};
    assign crc_sel   = bit_cnt[2:0] - 3'd1;
    assign cmd_valid = (state == ST_CHECK);
    assign fsm_state = state;

    crc7 u_crc7 (
        .clk  (clk),
        .rst  (rst | crc_rst),
        .en   (crc_en),
        .data (crc_din),
        .crc  (crc)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        ncr_n     = ncr_cnt;
        rx_sr_n   = rx_sr;
        tx_sr_n   = tx_sr;
        idx_n     = cmd_index;
        arg_n     = cmd_arg;
        ok_n      = cmd_crc_ok;
        drop_n    = 1'b0;
        out_n     = sd_cmd_out;
        oe_n      = sd_cmd_oe;
        crc_rst   = 1'b0;
        crc_en    = 1'b0;
        crc_din   = 1'b0;
        rsp_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                // The start bit is 0, so clearing the CRC here equals feeding it.
                if (rise && cmd_bit == START_BIT) begin
                    state_n   = ST_RX;
                    bit_cnt_n = 6'd47;
                    rx_sr_n   = frame[45:0];
                    crc_rst   = 1'b1;
                end
            end
            ST_RX: begin
                // bit_cnt holds the index of the last bit captured.
                if (rise) begin
                    rx_sr_n   = frame[45:0];
                    bit_cnt_n = bit_cnt - 6'd1;
                    if (bit_cnt >= 6'd9) begin
                        crc_en  = 1'b1;
                        crc_din = cmd_bit;
                    end
                    if (bit_cnt == 6'd1) begin
                        state_n = ST_CHECK;
                        idx_n   = frame[45:40];
                        arg_n   = frame[39:8];
                        ok_n    = (frame[46] == HOST_TX_BIT) && (frame[7:1] == crc) &&
                                  (cmd_bit == END_BIT);
                    end
                end
            end
            ST_CHECK: begin
                state_n = ST_WAIT_RSP;
                ncr_n   = '0;
            end
            ST_WAIT_RSP: begin
                if (rise && cmd_bit == START_BIT) begin
                    drop_n    = 1'b1;
                    state_n   = ST_RX;
                    bit_cnt_n = 6'd47;
                    rx_sr_n   = frame[45:0];
                    crc_rst   = 1'b1;
                end else if (rsp_valid && ncr_cnt >= NCR_MIN_C) begin
                    rsp_ready = 1'b1;
                    if (rsp_skip) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_TX;
                        tx_sr_n   = {START_BIT, CARD_TX_BIT, rsp_index, rsp_arg};
                        bit_cnt_n = 6'd47;
                        crc_rst   = 1'b1;
                    end
                end else if (ncr_cnt >= NCR_MAX_C) begin
                    drop_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (rise) begin
                    ncr_n = ncr_cnt + 7'd1;
                end
            end
            ST_TX: begin
                // bit_cnt holds the index of the next bit to drive.
                if (fall) begin
                    oe_n      = 1'b1;
                    bit_cnt_n = bit_cnt - 6'd1;
                    if (bit_cnt >= 6'd8) begin
                        out_n   = tx_sr[39];
                        tx_sr_n = {tx_sr[38:0], 1'b0};
                        crc_en  = 1'b1;
                        crc_din = tx_sr[39];
                    end else if (bit_cnt >= 6'd1) begin
                        out_n = crc[crc_sel];
                    end else begin
                        out_n     = END_BIT;
                        bit_cnt_n = 6'd1;
                        state_n   = ST_TX_END;
                    end
                end
            end
            ST_TX_END: begin
                // One extra sd_clk of driven 1 (P bit), then release the line.
                if (fall) begin
                    out_n = 1'b1;
                    if (bit_cnt != 6'd0) begin
                        bit_cnt_n = 6'd0;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            ncr_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            cmd_index   <= '0;
            cmd_arg     <= '0;
            cmd_crc_ok  <= 1'b0;
            rsp_dropped <= 1'b0;
            sd_cmd_out  <= 1'b1;
            sd_cmd_oe   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            ncr_cnt     <= ncr_n;
            rx_sr       <= rx_sr_n;
            tx_sr       <= tx_sr_n;
            cmd_index   <= idx_n;
            cmd_arg     <= arg_n;
            cmd_crc_ok  <= ok_n;
            rsp_dropped <= drop_n;
            sd_cmd_out  <= out_n;
            sd_cmd_oe   <= oe_n;
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: a host model drives command frames, a device model
// answers through the valid/ready port, and monitors check captured commands and
// transmitted response frames against expected queues.
module tb_sd_cmd_responder;
    import sd_pkg::*;

    localparam int NCR_MIN = 2;
    localparam int NCR_MAX = 64;

    logic        clk = 1'b0, rst = 1'b1, sd_clk = 1'b0, sd_cmd_in = 1'b1;
    logic        sd_cmd_out, sd_cmd_oe, cmd_valid, cmd_crc_ok, rsp_ready, rsp_dropped;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rsp_valid = 1'b0, rsp_skip = 1'b0;
    logic [5:0]  rsp_index = '0;
    logic [31:0] rsp_arg = '0;
    sd_state_e   fsm_state;

    sd_cmd_responder #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
        .clk(clk), .rst(rst), .sd_clk(sd_clk), .sd_cmd_in(sd_cmd_in),
        .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_ok(cmd_crc_ok),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_skip(rsp_skip),
        .rsp_index(rsp_index), .rsp_arg(rsp_arg), .rsp_dropped(rsp_dropped),
        .fsm_state(fsm_state)
    );

    // Clocks: sd_clk is 1/16 of clk.
    always #5 clk = ~clk;
    always #80 sd_clk = ~sd_clk;

    int n_cmp = 0, n_err = 0;
    logic [38:0] exp_cmd_q[$];   // {index, arg, crc_ok}
    logic [47:0] exp_rsp_q[$];
    logic [38:0] cmd_exp;
    logic [47:0] rsp_exp, cap;
    int  cmd_valid_cnt = 0, drop_cnt = 0, oe_clk_cnt = 0, aborted_frames = 0;
    int  cap_bits = 0, gap = 0, last_gap = -1;
    bit  capturing = 0, gap_arm = 0, gap_counting = 0;
    logic line;

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {1'b0, 1'b1, idx, arg};
        return {body, crc7_model(body), 1'b1};
    endfunction

    function automatic logic [47:0] make_rsp(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {1'b0, 1'b0, idx, arg};
        return {body, crc7_model(body), 1'b1};
    endfunction

    // Command scoreboard: every cmd_valid pulse pops one expected capture.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_dropped) drop_cnt++;
            if (sd_cmd_oe) oe_clk_cnt++;
            if (cmd_valid) begin
                cmd_valid_cnt++;
                n_cmp++;
                if (exp_cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_unexpected: got idx=%0d arg=%h ok=%b, required no capture",
                             cmd_index, cmd_arg, cmd_crc_ok);
                end else begin
                    cmd_exp = exp_cmd_q.pop_front();
                    if ({cmd_index, cmd_arg, cmd_crc_ok} !== cmd_exp) begin
                        n_err++;
                        $display("FAIL cmd_capture: got idx=%0d arg=%h ok=%b, required idx=%0d arg=%h ok=%b",
                                 cmd_index, cmd_arg, cmd_crc_ok, cmd_exp[38:33], cmd_exp[32:1], cmd_exp[0]);
                    end
                end
            end
        end
    end

    // Host-side view of the CMD line: NCR gap measurement and response capture.
    always @(posedge sd_clk) begin
        line = sd_cmd_oe ? sd_cmd_out : 1'b1;
        if (gap_arm) begin
            gap_arm = 0; gap_counting = 1; gap = 0;
        end else if (gap_counting) begin
            if (line == 1'b0) begin last_gap = gap; gap_counting = 0; end
            else gap++;
        end
        if (capturing) begin
            if (!sd_cmd_oe) begin
                capturing = 0; aborted_frames++;
            end else begin
                cap = {cap[46:0], sd_cmd_out};
                cap_bits++;
                if (cap_bits == 48) begin
                    capturing = 0;
                    n_cmp++;
                    if (exp_rsp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rsp_unexpected: got frame %h, required none", cap);
                    end else begin
                        rsp_exp = exp_rsp_q.pop_front();
                        if (cap !== rsp_exp) begin
                            n_err++;
                            $display("FAIL rsp_frame: got %h, required %h", cap, rsp_exp);
                        end
                    end
                end
            end
        end else if (sd_cmd_oe && sd_cmd_out == 1'b0) begin
            capturing = 1; cap = '0; cap_bits = 1;
        end
    end

    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            sd_cmd_in = f[i];
        end
        gap_arm = 1;
        @(negedge sd_clk);
        sd_cmd_in = 1'b1;
    endtask

    task automatic respond(input logic skip, input logic [5:0] idx, input logic [31:0] arg,
                           output bit ok);
        ok = 0;
        @(negedge clk);
        rsp_valid = 1'b1; rsp_skip = skip; rsp_index = idx; rsp_arg = arg;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (rsp_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        rsp_valid = 1'b0; rsp_skip = 1'b0;
    endtask

    task automatic wait_cmd(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_valid_cnt >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(input int max_clk, output bit ok);
        ok = 0;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk);
            if (fsm_state == ST_IDLE && !sd_cmd_oe) begin ok = 1; break; end
        end
    endtask

    task automatic wait_rsp_empty(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_rsp_q.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_valid = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if ({sd_cmd_oe, sd_cmd_out} !== 2'b01) begin n_err++;
            $display("FAIL reset_line: got oe/out=%b%b, required 01", sd_cmd_oe, sd_cmd_out); end
        n_cmp++; if ({cmd_valid, cmd_index, cmd_arg, cmd_crc_ok} !== 40'd0) begin n_err++;
            $display("FAIL reset_cmd: got valid=%b idx=%0d arg=%h ok=%b, required all 0",
                     cmd_valid, cmd_index, cmd_arg, cmd_crc_ok); end
        n_cmp++; if ({rsp_ready, rsp_dropped} !== 2'b00) begin n_err++;
            $display("FAIL reset_rsp: got ready/dropped=%b%b, required 00", rsp_ready, rsp_dropped); end
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_err++;
            $display("FAIL reset_state: got %0d, required %0d", fsm_state, ST_IDLE); end
        rsp_valid = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_cmd0();
        int c0, o0; bit ok;
        c0 = cmd_valid_cnt; o0 = oe_clk_cnt;
        exp_cmd_q.push_back({6'd0, 32'd0, 1'b1});
        send_cmd(48'h400000000095);
        wait_cmd(c0 + 1, ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL cmd0_capture: cmd_valid count %0d, required %0d", cmd_valid_cnt, c0 + 1); end
        respond(1'b1, 6'd0, 32'd0, ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL cmd0_skip_ready: rsp_ready=0 until timeout, required 1"); end
        repeat (320) @(negedge clk);
        n_cmp++; if (oe_clk_cnt !== o0) begin n_err++;
            $display("FAIL cmd0_oe: got %0d driven clks, required 0", oe_clk_cnt - o0); end
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_err++;
            $display("FAIL cmd0_state: got %0d, required %0d", fsm_state, ST_IDLE); end
        n_cmp++; if (cmd_valid_cnt !== c0 + 1) begin n_err++;
            $display("FAIL cmd0_pulses: got %0d, required 1", cmd_valid_cnt - c0); end
    endtask

    task automatic test_cmd8();
        int c0; bit ok;
        c0 = cmd_valid_cnt; last_gap = -1;
        exp_cmd_q.push_back({6'd8, 32'h000001AA, 1'b1});
        exp_rsp_q.push_back(make_rsp(6'd8, 32'h000001AA));
        send_cmd(48'h48000001AA87);
        wait_cmd(c0 + 1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd8_capture: no cmd_valid, required 1"); end
        respond(1'b0, 6'd8, 32'h000001AA, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd8_ready: rsp_ready=0 until timeout, required 1"); end
        wait_rsp_empty(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd8_rsp_timeout: response not seen, required 1 frame"); end
        n_cmp++; if (last_gap !== NCR_MIN) begin n_err++;
            $display("FAIL cmd8_ncr_gap: got %0d sd_clk, required %0d", last_gap, NCR_MIN); end
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd8_release: line still driven, required idle"); end
    endtask

    task automatic test_cmd17();
        int c0; bit ok;
        c0 = cmd_valid_cnt;
        exp_cmd_q.push_back({6'd17, 32'h00000900, 1'b1});
        exp_rsp_q.push_back(48'h110000090067);
        send_cmd(make_cmd(6'd17, 32'h00000900));
        wait_cmd(c0 + 1, ok);
        respond(1'b0, 6'd17, 32'h00000900, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd17_ready: rsp_ready=0 until timeout, required 1"); end
        wait_rsp_empty(ok);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cmd17_release: state %0d, required idle", fsm_state); end
    endtask

    task automatic test_bad_frames();
        logic [47:0] frames [3];
        bit ok;
        int c0;
        frames[0] = 48'h400000000097;   // CRC bit flipped
        frames[1] = 48'h400000000094;   // end bit 0
        frames[2] = 48'h000000000001;   // transmission bit 0, CRC consistent
        for (int i = 0; i < 3; i++) begin
            c0 = cmd_valid_cnt;
            exp_cmd_q.push_back({6'd0, 32'd0, 1'b0});
            send_cmd(frames[i]);
            wait_cmd(c0 + 1, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL bad_frame_%0d: no cmd_valid, required 1", i); end
            respond(1'b1, 6'd0, 32'd0, ok);
            wait_idle(200, ok);
        end
    endtask

    task automatic test_timeout();
        int c0, d0, o0; bit ok;
        c0 = cmd_valid_cnt; d0 = drop_cnt; o0 = oe_clk_cnt;
        exp_cmd_q.push_back({6'd55, 32'd0, 1'b1});
        send_cmd(make_cmd(6'd55, 32'd0));
        wait_cmd(c0 + 1, ok);
        ok = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (drop_cnt != d0 && fsm_state == ST_IDLE) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_drop: no rsp_dropped within bound, required 1"); end
        repeat (200) @(negedge clk);
        n_cmp++; if (drop_cnt !== d0 + 1) begin n_err++;
            $display("FAIL timeout_pulses: got %0d, required 1", drop_cnt - d0); end
        n_cmp++; if (oe_clk_cnt !== o0) begin n_err++;
            $display("FAIL timeout_oe: got %0d driven clks, required 0", oe_clk_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        int c0, d0; bit ok;
        logic [31:0] arg;
        arg = $urandom;
        c0 = cmd_valid_cnt; d0 = drop_cnt;
        exp_cmd_q.push_back({6'd55, 32'd0, 1'b1});
        exp_cmd_q.push_back({6'd17, arg, 1'b1});
        send_cmd(make_cmd(6'd55, 32'd0));
        send_cmd(make_cmd(6'd17, arg));
        wait_cmd(c0 + 2, ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL b2b_capture: got %0d captures, required 2", cmd_valid_cnt - c0); end
        n_cmp++; if (drop_cnt !== d0 + 1) begin n_err++;
            $display("FAIL b2b_drop: got %0d pulses, required 1", drop_cnt - d0); end
        respond(1'b1, 6'd0, 32'd0, ok);
        wait_idle(200, ok);
    endtask

    task automatic test_rst_mid_tx();
        int c0, a0; bit ok;
        c0 = cmd_valid_cnt; a0 = aborted_frames;
        exp_cmd_q.push_back({6'd8, 32'h000001AA, 1'b1});
        send_cmd(48'h48000001AA87);
        wait_cmd(c0 + 1, ok);
        respond(1'b0, 6'd8, 32'h000001AA, ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (capturing && cap_bits >= 20) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_tx_start: response never reached bit 20"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({sd_cmd_oe, sd_cmd_out} !== 2'b01) begin n_err++;
            $display("FAIL rst_tx_release: got oe/out=%b%b, required 01", sd_cmd_oe, sd_cmd_out); end
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_err++;
            $display("FAIL rst_tx_state: got %0d, required %0d", fsm_state, ST_IDLE); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if (aborted_frames !== a0 + 1) begin n_err++;
            $display("FAIL rst_tx_abort: got %0d aborted, required 1", aborted_frames - a0); end
        c0 = cmd_valid_cnt;
        exp_cmd_q.push_back({6'd8, 32'h000001AA, 1'b1});
        send_cmd(48'h48000001AA87);
        wait_cmd(c0 + 1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_tx_recover: no capture after reset, required 1"); end
        respond(1'b1, 6'd0, 32'd0, ok);
        wait_idle(200, ok);
    endtask

    task automatic test_random();
        logic [5:0] idx, ridx;
        logic [31:0] arg, rarg;
        int c0; bit ok;
        for (int n = 0; n < 4; n++) begin
            idx = 6'($urandom_range(0, 63)); arg = $urandom;
            ridx = 6'($urandom_range(0, 63)); rarg = $urandom;
            c0 = cmd_valid_cnt;
            exp_cmd_q.push_back({idx, arg, 1'b1});
            exp_rsp_q.push_back(make_rsp(ridx, rarg));
            send_cmd(make_cmd(idx, arg));
            wait_cmd(c0 + 1, ok);
            respond(1'b0, ridx, rarg, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL random_%0d_ready: rsp_ready=0, required 1", n); end
            wait_rsp_empty(ok);
            wait_idle(200, ok);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17();
        test_bad_frames();
        test_timeout();
        test_back_to_back();
        test_rst_mid_tx();
        test_random();
        repeat (50) @(negedge clk);
        n_cmp++; if (exp_cmd_q.size() != 0) begin n_err++;
            $display("FAIL cmd_leftover: %0d captures missing, required 0", exp_cmd_q.size()); end
        n_cmp++; if (exp_rsp_q.size() != 0) begin n_err++;
            $display("FAIL rsp_leftover: %0d frames missing, required 0", exp_rsp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
